// File: rtl/trx_trigger_pkg.sv
// trx_trigger_pkg: shared state encoding, default widths and register-map field positions
package trx_trigger_pkg;
  localparam int CNT_WIDTH_DEF = 32;
  localparam int BURST_WIDTH_DEF = 16;
  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_ARMED  = 6'b000010,
    ST_DELAY  = 6'b000100,
    ST_ACTIVE = 6'b001000,
    ST_GAP    = 6'b010000,
    ST_DONE   = 6'b100000
  } state_t;
  // word offsets of the config fields and control bits in the bus-register block
  localparam int REG_DELAY = 0;
  localparam int REG_WIDTH = 1;
  localparam int REG_PERIOD = 2;
  localparam int REG_BURST = 3;
  localparam int REG_CTRL = 4;
  localparam int CTRL_ARM_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;
endpackage

// File: rtl/trx_trig_downcnt.sv
// trx_trig_downcnt: loadable down-counter that saturates at zero and flags terminal count
module trx_trig_downcnt #(
  parameter int C_CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   en,
  input  logic [C_CNT_WIDTH-1:0] value,
  output logic                   tc
);
  logic [C_CNT_WIDTH-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/trx_trigger_sequencer.sv
// trx_trigger_sequencer: after arming, turns a trigger rising edge into a delayed burst of enable pulses
module trx_trigger_sequencer
  import trx_trigger_pkg::*;
#(
  parameter int C_CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int C_BURST_WIDTH = BURST_WIDTH_DEF
) (
  input  logic                     i_DesignClk_p,
  input  logic                     i_Rst_p,
  input  logic                     i_TrigIn_p,
  input  logic                     i_Arm_p,
  input  logic                     i_Abort_p,
  input  logic [C_CNT_WIDTH-1:0]   i_Delay_p,
  input  logic [C_CNT_WIDTH-1:0]   i_Width_p,
  input  logic [C_CNT_WIDTH-1:0]   i_Period_p,
  input  logic [C_BURST_WIDTH-1:0] i_BurstCount_p,
  output logic                     o_En_p,
  output logic                     o_Armed_p,
  output logic                     o_Busy_p,
  output logic                     o_Done_p,
  output logic                     o_TrigMissed_p,
  output logic [C_BURST_WIDTH-1:0] o_BurstIdx_p
);
  state_t state, nxt;
  logic trig_q, trig_edge, last, tc, ld;
  logic [C_CNT_WIDTH-1:0] delay_q, width_q, gap_q, width_s, ld_val;
  logic [C_BURST_WIDTH-1:0] burst_q;
  assign trig_edge = i_TrigIn_p & ~trig_q;
  assign o_Armed_p = state == ST_ARMED;
  assign o_Busy_p = state inside {ST_DELAY, ST_ACTIVE, ST_GAP};
  assign last = o_BurstIdx_p == burst_q - 1'b1;
  assign width_s = i_Width_p == '0 ? C_CNT_WIDTH'(1) : i_Width_p;
  always_comb begin
    nxt = state;
    if (i_Abort_p && state != ST_IDLE) nxt = ST_IDLE;
    else
      case (state)
        ST_IDLE:   if (i_Arm_p) nxt = ST_ARMED;
        ST_ARMED:  if (trig_edge) nxt = delay_q != '0 ? ST_DELAY : ST_ACTIVE;
        ST_DELAY:  if (tc) nxt = ST_ACTIVE;
        ST_ACTIVE: if (tc) nxt = last ? ST_DONE : ST_GAP;
        ST_GAP:    if (tc) nxt = ST_ACTIVE;
        default:   nxt = ST_IDLE;
      endcase
  end
  // the single counter is reloaded with (phase length - 1) on every state entry
  assign ld = nxt != state;
  assign ld_val = nxt == ST_DELAY ? delay_q - 1'b1 : nxt == ST_ACTIVE ? width_q - 1'b1 : gap_q - 1'b1;
  trx_trig_downcnt #(.C_CNT_WIDTH(C_CNT_WIDTH)) u_cnt (
    .clk(i_DesignClk_p),
    .rst(i_Rst_p),
    .load(ld),
    .en(o_Busy_p),
    .value(ld_val),
    .tc(tc)
  );
  always_ff @(posedge i_DesignClk_p or posedge i_Rst_p)
    if (i_Rst_p) begin
      state <= ST_IDLE;
      trig_q <= 1'b0;
      o_En_p <= 1'b0;
      o_Done_p <= 1'b0;
      o_TrigMissed_p <= 1'b0;
      o_BurstIdx_p <= '0;
      delay_q <= '0;
      width_q <= '0;
      gap_q <= '0;
      burst_q <= '0;
    end else begin
      state <= nxt;
      trig_q <= i_TrigIn_p;
      o_En_p <= nxt == ST_ACTIVE;
      o_Done_p <= state == ST_DONE && !i_Abort_p;
      if (state == ST_IDLE && i_Arm_p) begin
        delay_q <= i_Delay_p;
        width_q <= width_s;
        // gap = max(period, width+1) - width, written so width+1 can never overflow
        gap_q <= i_Period_p > width_s ? i_Period_p - width_s : C_CNT_WIDTH'(1);
        burst_q <= i_BurstCount_p == '0 ? C_BURST_WIDTH'(1) : i_BurstCount_p;
        o_TrigMissed_p <= 1'b0;
        o_BurstIdx_p <= '0;
      end
      if (o_Busy_p && trig_edge && !i_Abort_p) o_TrigMissed_p <= 1'b1;
      if (state == ST_GAP && nxt == ST_ACTIVE) o_BurstIdx_p <= o_BurstIdx_p + 1'b1;
    end
endmodule

// File: tb/tb_trx_trigger_sequencer.sv
// tb_trx_trigger_sequencer: randomized bursts checked against a pulse-schedule model
module tb_trx_trigger_sequencer;
  logic clk = 1'b0, rst = 1'b1, trig = 1'b0, arm = 1'b0, abort = 1'b0;
  logic [31:0] delay = '0, width = '0, period = '0;
  logic [15:0] burst = '0;
  logic en, armed, busy, done, missed;
  logic [15:0] idx;
  int vectors = 0, errors = 0;
  int md, mws, mpe, mbs;
  trx_trigger_sequencer dut (
    .i_DesignClk_p(clk),
    .i_Rst_p(rst),
    .i_TrigIn_p(trig),
    .i_Arm_p(arm),
    .i_Abort_p(abort),
    .i_Delay_p(delay),
    .i_Width_p(width),
    .i_Period_p(period),
    .i_BurstCount_p(burst),
    .o_En_p(en),
    .o_Armed_p(armed),
    .o_Busy_p(busy),
    .o_Done_p(done),
    .o_TrigMissed_p(missed),
    .o_BurstIdx_p(idx)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  // pulse k occupies samples [md+1+k*mpe, md+1+k*mpe+mws) counted from the trigger edge
  function automatic bit exp_en(int t);
    for (int k = 0; k < mbs; k++)
      if (t >= md + 1 + k * mpe && t < md + 1 + k * mpe + mws) return 1'b1;
    return 1'b0;
  endfunction
  function automatic int exp_idx(int t);
    int n = 0;
    for (int k = 0; k < mbs; k++)
      if (md + 1 + k * mpe <= t) n++;
    return n == 0 ? 0 : n - 1;
  endfunction
  task automatic arm_with(input int d, input int w, input int p, input int b);
    @(negedge clk);
    arm = 1'b1;
    delay = d;
    width = w;
    period = p;
    burst = 16'(b);
    @(negedge clk);
    arm = 1'b0;
    delay = $urandom;
    width = $urandom;
    period = $urandom;
    burst = 16'($urandom);
  endtask
  task automatic run_burst(input int d, input int w, input int p, input int b, input bit rnd);
    int done_t, nt, prev;
    bit miss, bsy;
    md = d;
    mws = w == 0 ? 1 : w;
    mbs = b == 0 ? 1 : b;
    mpe = p > mws + 1 ? p : mws + 1;
    done_t = md + (mbs - 1) * mpe + mws + 2;
    @(negedge clk);
    trig = 1'b0;
    arm_with(d, w, p, b);
    check("armed", armed, 1);
    check("missed_clr", missed, 0);
    check("idx_clr", idx, 0);
    trig = 1'b1;
    prev = 1;
    miss = 1'b0;
    for (int t = 1; t <= done_t + 1; t++) begin
      @(negedge clk);
      bsy = t <= done_t - 2;
      check("en", en, exp_en(t));
      check("done", done, t == done_t);
      check("busy", busy, bsy);
      check("armed_run", armed, 0);
      check("idx", idx, exp_idx(t));
      check("missed", missed, miss);
      nt = !rnd ? 1 : t == 2 ? 0 : t == 3 ? 1 : int'($urandom_range(0, 1));
      if (bsy && nt == 1 && prev == 0) miss = 1'b1;
      prev = nt;
      trig = nt[0];
      arm = rnd && bsy && $urandom_range(0, 3) == 0;
    end
    arm = 1'b0;
  endtask
  initial begin
    #1;
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    check("rst_armed", armed, 0);
    check("rst_done", done, 0);
    check("rst_missed", missed, 0);
    check("rst_idx", idx, 0);
    @(negedge clk);
    rst = 1'b0;
    run_burst(3, 2, 10, 1, 0);
    run_burst(0, 4, 3, 3, 1);
    run_burst(2, 0, 4, 0, 0);
    for (int i = 0; i < 25; i++)
      run_burst($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 9), $urandom_range(0, 3), 1);
    // abort on the second enabled cycle of an 8-cycle pulse
    @(negedge clk);
    trig = 1'b0;
    arm_with(0, 8, 10, 1);
    trig = 1'b1;
    @(negedge clk);
    check("abort_en1", en, 1);
    @(negedge clk);
    check("abort_en2", en, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_en", en, 0);
    check("abort_busy", busy, 0);
    check("abort_armed", armed, 0);
    check("abort_idx", idx, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_nodone", done, 0);
      check("abort_en_low", en, 0);
    end
    // trigger already high when armed must not start a burst
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    arm_with(2, 1, 2, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("held_armed", armed, 1);
      check("held_busy", busy, 0);
    end
    trig = 1'b0;
    @(negedge clk);
    check("held_low_armed", armed, 1);
    trig = 1'b1;
    @(negedge clk);
    check("held_rise_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("held_abort_busy", busy, 0);
    // asynchronous reset while in the gap after the second pulse
    trig = 1'b0;
    arm_with(0, 1, 3, 3);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    @(negedge clk);
    trig = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("gap_idx", idx, 1);
    check("gap_missed", missed, 1);
    check("gap_busy", busy, 1);
    check("gap_en", en, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_idx", idx, 0);
    check("arst_missed", missed, 0);
    check("arst_busy", busy, 0);
    check("arst_en", en, 0);
    check("arst_armed", armed, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_idle_busy", busy, 0);
    check("arst_idle_armed", armed, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/trx_trigger_sequencer.md
# trx_trigger_sequencer

Sequences the radio enable line from a synchronized trigger: once armed, waits for a trigger rising edge, waits a programmable delay, then emits a burst of enable pulses of programmable width and period. Sits in the `i_DesignClk_p` domain downstream of the trigger CDC syncer. It drives the transceiver enable in place of the checkpoint-toggle logic. Configuration comes from the bus-register block and is latched at arm time.

## Interface
Parameters:
- `C_CNT_WIDTH`, 32: width of the delay, width and period counters.
- `C_BURST_WIDTH`, 16: width of the burst count and burst index.

Ports:
- `i_DesignClk_p`, in, 1: the block's single clock.
- `i_Rst_p`, in, 1: reset, asynchronous and active-high.
- `i_TrigIn_p`, in, 1: trigger, already synchronized to `i_DesignClk_p`, level.
- `i_Arm_p`, in, 1: arm request, single-cycle pulse.
- `i_Abort_p`, in, 1: abort request, single-cycle pulse.
- `i_Delay_p`, in, C_CNT_WIDTH: cycles from trigger detection to the first pulse.
- `i_Width_p`, in, C_CNT_WIDTH: enable high time in cycles.
- `i_Period_p`, in, C_CNT_WIDTH: start-to-start pulse spacing in cycles.
- `i_BurstCount_p`, in, C_BURST_WIDTH: number of pulses per trigger.
- `o_En_p`, out, 1: transceiver enable (registered).
- `o_Armed_p`, out, 1: high while waiting for a trigger.
- `o_Busy_p`, out, 1: high in DELAY, ACTIVE and GAP.
- `o_Done_p`, out, 1: one-cycle pulse when a burst completes normally.
- `o_TrigMissed_p`, out, 1: sticky flag; a trigger edge arrived while busy.
- `o_BurstIdx_p`, out, C_BURST_WIDTH: index of the current or last pulse, 0-based.

## Operation
- States: IDLE, ARMED, DELAY, ACTIVE, GAP, DONE.
- Reset values: state IDLE; all outputs 0; previous-trigger register 0.
- **Edge detect.** `edge = i_TrigIn_p & ~trig_q`, with `trig_q` registered every cycle in every state.
- **IDLE.**
  - `i_Arm_p` latches the four config inputs, clears `o_TrigMissed_p` and `o_BurstIdx_p`, then goes to ARMED.
  - `i_Arm_p` is ignored in every other state.
- **Config sanitizing at latch time:**
  - Width 0 is treated as 1.
  - BurstCount 0 is treated as 1.
  - Effective period = max(Period, Width+1), which guarantees at least one low cycle between pulses.
- **ARMED.** On `edge`: go to DELAY if Delay>0, otherwise go directly to ACTIVE.
- **DELAY.** Counts Delay cycles, then goes to ACTIVE.
- **ACTIVE.**
  - `o_En_p` is 1 for exactly Width cycles.
  - On exit: if `o_BurstIdx_p` = BurstCount-1, go to DONE; otherwise go to GAP.
- **GAP.**
  - `o_En_p` is 0 for (effective period − Width) cycles.
  - On exit: increment `o_BurstIdx_p` and go to ACTIVE.
- **DONE.** Lasts one cycle, with `o_Done_p` = 1, then goes to IDLE.
- **Missed triggers.** An `edge` in DELAY, ACTIVE or GAP sets `o_TrigMissed_p` and does not restart the sequence.
- **Abort.**
  - `i_Abort_p` in any non-IDLE state goes to IDLE on the next edge.
  - `o_En_p` drops to 0 on that same edge.
  - No `o_Done_p` is produced; `o_BurstIdx_p` and `o_TrigMissed_p` hold their values.
- **Priority when events coincide.** Abort beats everything. An `edge` coinciding with arm in IDLE is not seen, because arming takes effect next cycle.
- **Arithmetic.**
  - Counters are down-counters, loaded with value−1 and terminating at 0, so they never wrap.
  - The burst index comparison is unsigned.
- **Reset mid-operation.** Asynchronous return to the reset values above.

## Timing
- Let edge E be the clock edge at which `edge` is 1 in ARMED.
- With Delay=D, `o_En_p` rises at edge E+D+1 and stays high for Width clock periods.
- Pulse k (0-based) rises at edge E+D+1+k·Peff, where Peff is the effective period.
- `o_Done_p` is high in the cycle after the last pulse falls.
- `o_Armed_p` and `o_Busy_p` are Moore outputs decoded from the state register.
- `o_Armed_p` rises one cycle after `i_Arm_p`.
- Config inputs are don't-care except in the cycle where `i_Arm_p` is sampled in IDLE.

## Structure
- Shared package `trx_trigger_pkg`:
  - state encoding constants (one-hot, 6 bits);
  - default widths;
  - config field bit positions for the register map.
- One sub-module, `trx_trig_downcnt`: loadable down-counter with load, enable and terminal-count (`tc`) output, parameterized on C_CNT_WIDTH.
- One instance is shared by DELAY, ACTIVE and GAP; it is reloaded on every state entry.

## Test plan
- **Single pulse.** Delay=3, Width=2, Period=10, Burst=1; arm, then trigger rises → `o_En_p` high at E+4 and E+5, `o_Done_p` at E+7, then IDLE.
- **Burst spacing and clamps.**
  - Delay=0, Width=4, Period=3 (clamped to 5), Burst=3 → pulses start at E+1, E+6, E+11; `o_BurstIdx_p` steps 0, 1, 2.
  - Width=0 / Burst=0 → exactly one 1-cycle pulse.
- **Missed trigger.** Second trigger edge during ACTIVE → `o_TrigMissed_p`=1, pulse train unchanged. Cleared by the next arm.
- **Abort in ACTIVE.** Abort on the 2nd cycle of Width=8 → `o_En_p` 0 on the next edge, IDLE, no `o_Done_p`.
- **Arm while busy, held trigger.**
  - Arm while busy → ignored.
  - Trigger held high before arm → no start until it goes low then high again.
- **Asynchronous reset in GAP.** Assert `i_Rst_p` between clock edges → all outputs 0 immediately, state IDLE.
